// File: rtl/load_scoreboard.sv
// load_scoreboard
// Tracks architectural registers with an outstanding variable-latency load,
// stalls decode on RAW/WAW hazards against them or on a full load budget,
// and squashes the IF/ID and ID/EX slots when EX resolves a taken branch.
// Clears from load responses are registered, so a dependent instruction
// releases the cycle after the response, when the data is reachable.
module load_scoreboard #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rd,
  input  logic             id_regWrite,
  input  logic             id_memRead,
  input  logic             ex_branch_taken,
  input  logic             mem_rsp_valid,
  input  logic [4:0]       mem_rsp_rd,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             bubble_id_ex,
  output logic             flush_if_id,
  output logic             id_issue,
  output logic [31:0]      pending_mask,
  output logic [CNT_W-1:0] outstanding,
  output logic             rsp_err,
  output logic [31:0]      stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

  logic [31:0]      pending_r;
  logic [CNT_W-1:0] outstanding_r;
  logic             rsp_err_r;
  logic [31:0]      stall_cycles_r;

  logic             raw_s;
  logic             waw_s;
  logic             full_s;
  logic             hazard_s;
  logic             stall_s;
  logic             issue_s;
  logic             load_issue_s;
  logic             rsp_ok_s;
  logic             rsp_bad_s;
  logic [31:0]      set_mask_s;
  logic [31:0]      clr_mask_s;
  logic [31:0]      pending_next_s;
  logic [CNT_W-1:0] outstanding_next_s;

  // Hazard detection against the pending set (bit 0 is never set, so x0 never hazards).
  always_comb begin
    raw_s    = (id_rs1_used & pending_r[id_rs1]) | (id_rs2_used & pending_r[id_rs2]);
    waw_s    = id_regWrite & pending_r[id_rd];
    full_s   = id_memRead & (outstanding_r == CNT_MAX);
    hazard_s = id_valid & (raw_s | waw_s | full_s);
  end

  // Pipeline control: reset silences everything, a taken branch beats a hazard stall.
  always_comb begin
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    issue_s      = 1'b0;
    stall_s      = 1'b0;
    if (reset) begin
      issue_s = 1'b0;
    end else if (ex_branch_taken) begin
      flush_if_id  = 1'b1;
      bubble_id_ex = 1'b1;
    end else if (hazard_s) begin
      stall_pc     = 1'b1;
      stall_if_id  = 1'b1;
      bubble_id_ex = 1'b1;
      stall_s      = 1'b1;
    end else begin
      issue_s = id_valid;
    end
  end

  assign id_issue = issue_s;

  // Classify the returning response: valid only if a load is in flight and rd is pending (or x0).
  always_comb begin
    load_issue_s = issue_s & id_memRead;
    rsp_ok_s     = 1'b0;
    rsp_bad_s    = 1'b0;
    if (mem_rsp_valid) begin
      if ((outstanding_r != CNT_ZERO) &&
          ((mem_rsp_rd == 5'd0) || pending_r[mem_rsp_rd])) begin
        rsp_ok_s = 1'b1;
      end else begin
        rsp_bad_s = 1'b1;
      end
    end else begin
      rsp_ok_s  = 1'b0;
      rsp_bad_s = 1'b0;
    end
  end

  // Build set/clear masks; applying the set after the clear makes set win on a collision.
  always_comb begin
    set_mask_s = 32'd0;
    clr_mask_s = 32'd0;
    if (load_issue_s && (id_rd != 5'd0)) begin
      set_mask_s[id_rd] = 1'b1;
    end else begin
      set_mask_s = 32'd0;
    end
    if (rsp_ok_s) begin
      clr_mask_s[mem_rsp_rd] = 1'b1;
    end else begin
      clr_mask_s = 32'd0;
    end
    pending_next_s    = ((pending_r & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;
  end

  // Outstanding count: issue and accepted response in the same cycle cancel out.
  always_comb begin
    case ({load_issue_s, rsp_ok_s})
      2'b10:   outstanding_next_s = outstanding_r + CNT_ONE;
      2'b01:   outstanding_next_s = outstanding_r - CNT_ONE;
      default: outstanding_next_s = outstanding_r;
    endcase
  end

  // Scoreboard state, sticky error flag and saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r      <= 32'd0;
      outstanding_r  <= CNT_ZERO;
      rsp_err_r      <= 1'b0;
      stall_cycles_r <= 32'd0;
    end else begin
      pending_r     <= pending_next_s;
      outstanding_r <= outstanding_next_s;
      if (rsp_bad_s) begin
        rsp_err_r <= 1'b1;
      end
      if (stall_s && (stall_cycles_r != 32'hFFFF_FFFF)) begin
        stall_cycles_r <= stall_cycles_r + 32'd1;
      end
    end
  end

  assign pending_mask = pending_r;
  assign outstanding  = outstanding_r;
  assign rsp_err      = rsp_err_r;
  assign stall_cycles = stall_cycles_r;

endmodule
